shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Control stage directly upstream of the team's 8-bit shift register. It accepts a shift request (operand, direction, mode, amount) over a valid/ready handshake. It then drives the register's load/shift control lines cycle by cycle: one load, followed by N single-bit shifts. When the sequence finishes it presents the register's final contents on a result valid/ready handshake, so the ALU datapath can issue multi-bit shifts and rotates without per-cycle control.

Parameters:
WIDTH, 8, operand/register width; fixed at 8 to match the register.
CNT_W, 4, width of the shift-amount field and the internal counter.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_data  input  8  operand to load into the register.
- req_dir  input  1  0 = shift right (toward bit 0), 1 = shift left.
- req_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 fill with req_fill.
- req_fill  input  1  fill bit used when req_mode = 11.
- req_amount  input  4  number of single-bit shifts; values above 8 are clamped to 8.
- shift  output  2  register control: 00 hold, 01 right, 10 left, 11 load.
- load_data  output  8  operand presented to the register.
- D0  output  1  serial fill bit into the register (MSB on right shift, LSB on left shift).
- load_D0  output  1  tied low.
- q_in  input  8  register Q output, fed back.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  8  final register contents.

Behaviour:
- Async reset (resetn = 0):
  - state = IDLE; all latched request fields = 0; counter = 0.
  - Outputs: shift = 00, load_data = 0, D0 = 0, load_D0 = 0, req_ready = 1 (once resetn = 1), res_valid = 0, res_data = 0.
- Reset mid-operation: return to IDLE immediately and abandon the sequence. shift goes to 00 combinationally; no result is produced.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE:
    - req_ready = 1, shift = 00.
    - On req_valid & req_ready: latch data, dir, mode, fill; latch amount as min(req_amount, 8); go to LOAD.
  - LOAD:
    - shift = 11, load_data = latched data; lasts exactly one cycle.
    - Next state: SHIFT if amount > 0, else DONE. Counter is loaded with amount.
  - SHIFT:
    - shift = 01 if dir = 0, 10 if dir = 1.
    - Counter decrements each cycle; go to DONE on the cycle the counter reaches 1 (exactly amount shift cycles).
  - DONE:
    - shift = 00 (register holds), res_valid = 1, res_data = q_in.
    - On res_ready, go to IDLE. Hold indefinitely while res_ready = 0.
- res_data is q_in while res_valid = 1, and 0 otherwise.
- D0 selection, evaluated combinationally from q_in during SHIFT (0 in all other states):
  - Right: logical → 0; arithmetic → q_in[7]; rotate → q_in[0]; fill → fill.
  - Left: logical → 0; arithmetic → 0; rotate → q_in[7]; fill → fill.
- load_D0 is held at 0 at all times.
- Latency: with the request accepted at edge E0, res_valid is first high in the cycle after edge E(N+1), i.e. N+2 cycles after acceptance (N = clamped amount).
- Only one request is in flight at a time. No new request is accepted in LOAD, SHIFT or DONE; req_ready = 0 in all three.
- The DONE→IDLE cycle does not also accept a request. The earliest next acceptance is the cycle after the result handshake.
- req_* changes while not accepted have no effect; fields are sampled only at acceptance.

Test Plan:
- req_data = 0xB4, dir = right, mode = logical, amount = 3 → one shift = 11 cycle, then three shift = 01 cycles; res_valid 5 cycles after acceptance; res_data = 0x16.
- 0xB4, right, arithmetic, amount 2 → D0 = 1 each shift cycle; res_data = 0xED. Then 0xB4, left, rotate, amount 4 → res_data = 0x4B.
- 0xB4, amount 0 → shift = 11 for one cycle, no shift cycles; res_valid 2 cycles after acceptance; res_data = 0xB4.
- amount = 12 clamped to 8 → exactly 8 shift cycles:
  - left logical of 0xB4 → 0x00;
  - right rotate of 0xB4 → 0xB4;
  - left fill with req_fill = 1 → 0xFF.
- Hold res_ready = 0 for 5 cycles in DONE → res_valid and res_data stable, shift = 00, req_ready = 0 throughout; req_valid pulses in that window are ignored. Raise res_ready → IDLE next cycle.
- Assert resetn = 0 during the 2nd SHIFT cycle of an 8-shift request → shift = 00 and res_valid = 0 immediately. After release, req_ready = 1 and a fresh 0x01 left logical 1 request returns 0x02.

Source files
------------

// File: rtl/shift_sequencer.sv
// Sequencer that drives an external 8-bit shift register through one load and N single-bit shifts.
// It then returns the register contents on a result valid/ready handshake.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [1:0]       req_mode,
    input  logic             req_fill,
    input  logic [CNT_W-1:0] req_amount,
    output logic [1:0]       shift,
    output logic [WIDTH-1:0] load_data,
    output logic             D0,
    output logic             load_D0,
    input  logic [WIDTH-1:0] q_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] MAX_AMOUNT = CNT_W'(WIDTH);

    localparam logic [1:0] SH_HOLD  = 2'b00;
    localparam logic [1:0] SH_RIGHT = 2'b01;
    localparam logic [1:0] SH_LEFT  = 2'b10;
    localparam logic [1:0] SH_LOAD  = 2'b11;

    localparam logic [1:0] MODE_LOGICAL = 2'b00;
    localparam logic [1:0] MODE_ARITH   = 2'b01;
    localparam logic [1:0] MODE_ROTATE  = 2'b10;
    localparam logic [1:0] MODE_FILL    = 2'b11;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic             fill_q;
    logic [CNT_W-1:0] amount_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] amount_clamped;
    logic             accept;

    assign req_ready      = (state == IDLE);
    assign accept         = req_valid && req_ready;
    assign amount_clamped = (req_amount > MAX_AMOUNT) ? MAX_AMOUNT : req_amount;
    assign load_D0        = 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            data_q   <= '0;
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            fill_q   <= 1'b0;
            amount_q <= '0;
            count_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                data_q   <= req_data;
                dir_q    <= req_dir;
                mode_q   <= req_mode;
                fill_q   <= req_fill;
                amount_q <= amount_clamped;
            end
            if (state == LOAD) begin
                count_q <= amount_q;
            end else if (state == SHIFT) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Leaving SHIFT when the counter reads 1 gives exactly amount_q shift cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = (amount_q != '0) ? SHIFT : DONE;
            SHIFT:   if (count_q == CNT_W'(1)) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shift     = SH_HOLD;
        load_data = '0;
        res_valid = 1'b0;
        res_data  = '0;
        case (state)
            LOAD: begin
                shift     = SH_LOAD;
                load_data = data_q;
            end
            SHIFT: begin
                shift = dir_q ? SH_LEFT : SH_RIGHT;
            end
            DONE: begin
                res_valid = 1'b1;
                res_data  = q_in;
            end
            default: begin
                shift = SH_HOLD;
            end
        endcase
    end

    // Serial bit entering the register: MSB side on right shifts, LSB side on left shifts.
    always_comb begin
        D0 = 1'b0;
        if (state == SHIFT) begin
            case (mode_q)
                MODE_LOGICAL: D0 = 1'b0;
                MODE_ARITH:   D0 = dir_q ? 1'b0 : q_in[WIDTH-1];
                MODE_ROTATE:  D0 = dir_q ? q_in[WIDTH-1] : q_in[0];
                MODE_FILL:    D0 = fill_q;
                default:      D0 = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the downstream 8-bit shift register and scoreboards results
// against expected values pushed when each request is accepted.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic       req_dir = 1'b0;
    logic [1:0] req_mode = 2'b00;
    logic       req_fill = 1'b0;
    logic [3:0] req_amount = 4'd0;
    logic [1:0] shift;
    logic [7:0] load_data;
    logic       D0;
    logic       load_D0;
    logic [7:0] q_reg = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;

    int checks = 0;
    int fails  = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic [1:0] mode;
        logic       fill;
        logic [3:0] amount;
        logic [7:0] exp_res;
        int         exp_shifts;
    } vec_t;

    vec_t vecs[10];

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_dir    (req_dir),
        .req_mode   (req_mode),
        .req_fill   (req_fill),
        .req_amount (req_amount),
        .shift      (shift),
        .load_data  (load_data),
        .D0         (D0),
        .load_D0    (load_D0),
        .q_in       (q_reg),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data)
    );

    always #5 clk = ~clk;

    // Behavioural model of the downstream shift register.
    always @(posedge clk) begin
        case (shift)
            2'b11:   q_reg <= load_data;
            2'b01:   q_reg <= {D0, q_reg[7:1]};
            2'b10:   q_reg <= {q_reg[6:0], D0};
            default: q_reg <= q_reg;
        endcase
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int lat;
        int loads;
        int shifts;
        int waited;
        logic ld_ok;
        logic side_ok;
        logic [1:0] dir_code;
        dir_code = v.dir ? 2'b10 : 2'b01;
        @(negedge clk);
        req_data   = v.data;
        req_dir    = v.dir;
        req_mode   = v.mode;
        req_fill   = v.fill;
        req_amount = v.amount;
        req_valid  = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        compare("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        sb_q.push_back(v.exp_res);
        #1;
        req_valid  = 1'b0;
        req_data   = ~v.data;
        req_dir    = ~v.dir;
        req_mode   = ~v.mode;
        req_fill   = ~v.fill;
        req_amount = 4'd5;
        lat = 0;
        loads = 0;
        shifts = 0;
        ld_ok = 1'b1;
        side_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (shift == 2'b11) begin
                loads++;
                if (load_data !== v.data) ld_ok = 1'b0;
            end else if (shift == dir_code) begin
                shifts++;
            end else if (shift != 2'b00) begin
                side_ok = 1'b0;
            end
            if (load_D0 !== 1'b0 || req_ready !== 1'b0) side_ok = 1'b0;
        end while (!res_valid && lat < 40);
        compare("latency", lat, v.exp_shifts + 2);
        compare("load_cycles", loads, 32'd1);
        compare("shift_cycles", shifts, v.exp_shifts);
        compare("load_data", {31'b0, ld_ok}, 32'd1);
        compare("side_signals", {31'b0, side_ok}, 32'd1);
    endtask

    task automatic check_output(input int hold_cycles);
        logic [7:0] data0;
        logic [7:0] exp;
        logic stable_ok;
        data0 = res_data;
        stable_ok = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            req_valid = i[0];
            req_data  = 8'($urandom);
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== data0 || shift !== 2'b00 || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        req_valid = 1'b0;
        if (hold_cycles > 0) compare("hold_stable", {31'b0, stable_ok}, 32'd1);
        if (sb_q.size() == 0) begin
            compare("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            compare("res_data", {24'b0, res_data}, {24'b0, exp});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        compare("req_ready_after_result", {31'b0, req_ready}, 32'd1);
        compare("res_valid_after_result", {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hB4, 1'b0, 2'b00, 1'b0, 4'd3,  8'h16, 3};
        vecs[1] = '{8'hB4, 1'b0, 2'b01, 1'b0, 4'd2,  8'hED, 2};
        vecs[2] = '{8'hB4, 1'b1, 2'b10, 1'b0, 4'd4,  8'h4B, 4};
        vecs[3] = '{8'hB4, 1'b0, 2'b00, 1'b0, 4'd0,  8'hB4, 0};
        vecs[4] = '{8'hB4, 1'b1, 2'b00, 1'b0, 4'd12, 8'h00, 8};
        vecs[5] = '{8'hB4, 1'b0, 2'b10, 1'b0, 4'd12, 8'hB4, 8};
        vecs[6] = '{8'hB4, 1'b1, 2'b11, 1'b1, 4'd12, 8'hFF, 8};
        vecs[7] = '{8'h0F, 1'b0, 2'b11, 1'b0, 4'd2,  8'h03, 2};
        vecs[8] = '{8'h81, 1'b0, 2'b01, 1'b0, 4'd1,  8'hC0, 1};
        vecs[9] = '{8'h81, 1'b1, 2'b01, 1'b0, 4'd1,  8'h02, 1};

        repeat (2) @(negedge clk);
        compare("reset_shift", {30'b0, shift}, 32'd0);
        compare("reset_res_valid", {31'b0, res_valid}, 32'd0);
        compare("reset_res_data", {24'b0, res_data}, 32'd0);
        compare("reset_load_data", {24'b0, load_data}, 32'd0);
        compare("reset_D0", {31'b0, D0}, 32'd0);
        compare("reset_load_D0", {31'b0, load_D0}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        compare("req_ready_after_reset", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            check_output(0);
        end

        // Back-pressure in DONE with ignored request pulses.
        apply_stimulus('{8'h3C, 1'b0, 2'b10, 1'b0, 4'd2, 8'h0F, 2});
        check_output(5);
        @(negedge clk);
        compare("pulses_not_accepted", {31'b0, req_ready}, 32'd1);

        // Reset in the second SHIFT cycle abandons the sequence.
        @(negedge clk);
        req_data   = 8'hFF;
        req_dir    = 1'b1;
        req_mode   = 2'b00;
        req_fill   = 1'b0;
        req_amount = 4'd12;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        compare("shift_before_abort", {30'b0, shift}, 32'd2);
        resetn = 1'b0;
        #1;
        compare("abort_shift", {30'b0, shift}, 32'd0);
        compare("abort_res_valid", {31'b0, res_valid}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        compare("req_ready_after_abort", {31'b0, req_ready}, 32'd1);
        apply_stimulus('{8'h01, 1'b1, 2'b00, 1'b0, 4'd1, 8'h02, 1});
        check_output(0);
        compare("scoreboard_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
